// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it. The frame format and the
// bit rate are captured from the inputs when a byte leaves the FIFO, so
// configuration changes only affect frames that have not started yet.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [7:0]               OUT_PORT,
  input  logic [1:0]               DBITS,
  input  logic                     PEN,
  input  logic                     OHEL,
  input  logic                     STOP2,
  input  logic [3:0]               BAUD,
  output logic                     TXRDY,
  output logic                     TX,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   div_q;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;
  logic [7:0]    data_q;
  logic [1:0]    dbits_q;
  logic          pen_q, ohel_q, stop2_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q;

  logic          push, pop, not_empty, btu, par;
  logic [2:0]    last_bit;

  function automatic logic [31:0] baud_div(input logic [3:0] sel);
    int unsigned rate;
    case (sel)
      4'd0:    rate = 300;
      4'd1:    rate = 1200;
      4'd2:    rate = 2400;
      4'd3:    rate = 4800;
      4'd4:    rate = 9600;
      4'd5:    rate = 19200;
      4'd6:    rate = 38400;
      4'd7:    rate = 57600;
      4'd8:    rate = 115200;
      4'd9:    rate = 230400;
      4'd10:   rate = 460800;
      default: rate = 921600;
    endcase
    return CLK_HZ / rate;
  endfunction

  assign TXRDY     = (level_q != FULL);
  assign not_empty = (level_q != '0);
  assign push      = load & TXRDY;
  assign btu       = (cnt_q == div_q - 32'd1);
  assign last_bit  = {1'b0, dbits_q} + 3'd4;
  assign TX        = tx_q;
  assign LEVEL     = level_q;
  assign OVF       = ovf_q;

  // Parity over the data bits actually sent, inverted for odd sense
  always_comb begin
    par = ohel_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i <= {29'd0, last_bit}) par = par ^ data_q[i];
    end
  end

  // FIFO occupancy update from accepted pushes and FSM pops
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= OUT_PORT;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      if (load && !TXRDY) ovf_q <= 1'b1;
    end
  end

  // Per-frame capture of the byte, format and bit-time divisor at pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      dbits_q <= '0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      stop2_q <= 1'b0;
      div_q   <= '0;
    end else if (pop) begin
      data_q  <= mem[rd_q];
      dbits_q <= DBITS;
      pen_q   <= PEN;
      ohel_q  <= OHEL;
      stop2_q <= STOP2;
      div_q   <= baud_div(BAUD);
    end
  end

  // State, bit-time counter, bit index and registered line output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; every non-idle state advances only on the bit-time pulse
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    cnt_d   = (state_q == IDLE || btu) ? '0 : cnt_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (btu) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (btu) begin
          if (bit_q == last_bit) begin
            state_d = pen_q ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (btu) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (btu) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else if (not_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX is registered with no extra latency
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_d];
      PARITY:  tx_d = par;
      default: tx_d = 1'b1;
    endcase
    BUSY = (state_q != IDLE) || not_empty;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference builds each expected frame
// as a per-clock line waveform and is compared against the DUT every cycle.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [7:0]    OUT_PORT = '0;
  logic [1:0]    DBITS = 2'b11;
  logic          PEN = 1'b0;
  logic          OHEL = 1'b0;
  logic          STOP2 = 1'b0;
  logic [3:0]    BAUD = 4'd11;
  logic          TXRDY, TX, BUSY, OVF;
  logic [LW-1:0] LEVEL;

  int n_cmp = 0;
  int n_mis = 0;

  int unsigned rates [16] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                              115200, 230400, 460800, 921600, 921600, 921600,
                              921600, 921600};

  logic [7:0] mq [$];
  bit         line [$];
  bit         m_tx  = 1'b1;
  bit         m_ovf = 1'b0;
  int         m_pre;
  int         burst_left = 0;

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load(load), .OUT_PORT(OUT_PORT), .DBITS(DBITS),
    .PEN(PEN), .OHEL(OHEL), .STOP2(STOP2), .BAUD(BAUD), .TXRDY(TXRDY),
    .TX(TX), .BUSY(BUSY), .LEVEL(LEVEL), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expand one frame into per-clock line values using the current inputs.
  function automatic void build_frame(input logic [7:0] b);
    int unsigned div;
    int unsigned n;
    int unsigned ones;
    bit fb [$];
    div  = CLK_HZ / rates[BAUD];
    n    = int'(DBITS) + 5;
    ones = 0;
    fb.push_back(1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      fb.push_back(b[i]);
      ones += b[i];
    end
    if (PEN) fb.push_back(((ones % 2) == 1) ^ OHEL);
    fb.push_back(1'b1);
    if (STOP2) fb.push_back(1'b1);
    foreach (fb[k]) begin
      for (int unsigned c = 0; c < div; c++) line.push_back(fb[k]);
    end
  endfunction

  // Reference model: line[0] is the level expected during the clock after each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      line.delete();
      m_tx  = 1'b1;
      m_ovf = 1'b0;
    end else begin
      m_pre = mq.size();
      if (line.size() > 1) begin
        void'(line.pop_front());
      end else begin
        line.delete();
        if (m_pre > 0) build_frame(mq.pop_front());
      end
      m_tx = (line.size() > 0) ? line[0] : 1'b1;
      if (load) begin
        if (m_pre < int'(DEPTH)) mq.push_back(OUT_PORT);
        else m_ovf = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the reference, away from the rising edge
  always @(negedge clk) begin
    chk("TX",    32'(TX),    32'(m_tx));
    chk("LEVEL", 32'(LEVEL), 32'(mq.size()));
    chk("TXRDY", 32'(TXRDY), (mq.size() < int'(DEPTH)) ? 32'd1 : 32'd0);
    chk("BUSY",  32'(BUSY),  (line.size() > 0 || mq.size() > 0) ? 32'd1 : 32'd0);
    chk("OVF",   32'(OVF),   32'(m_ovf));
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    load     = 1'b1;
    OUT_PORT = b;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max_cyc);
    for (int unsigned c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (line.size() == 0 && mq.size() == 0) break;
    end
    chk("idle_busy", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_TX",    32'(TX),    32'd1);
    chk("rst_TXRDY", 32'(TXRDY), 32'd1);
    chk("rst_BUSY",  32'(BUSY),  32'd0);
    chk("rst_LEVEL", 32'(LEVEL), 32'd0);
    chk("rst_OVF",   32'(OVF),   32'd0);

    // 8N1 at 921600 with a push on the very first edge out of reset
    rst      = 1'b1;
    load     = 1'b1;
    OUT_PORT = 8'h55;
    @(negedge clk);
    load = 1'b0;
    chk("first_push_LEVEL", 32'(LEVEL), 32'd1);
    wait_idle(3000);

    // 7 data bits, odd parity
    DBITS = 2'b10; PEN = 1'b1; OHEL = 1'b1;
    push(8'h55);
    wait_idle(3000);

    // Rate change mid-frame only applies to the following frame
    DBITS = 2'b11; PEN = 1'b0; OHEL = 1'b0; BAUD = 4'd11;
    push(8'hA3);
    repeat (200) @(negedge clk);
    BAUD = 4'd8;
    push(8'h3C);
    wait_idle(15000);
    BAUD = 4'd11;

    // Two stop bits, back-to-back frames without idle gap
    STOP2 = 1'b1;
    push(8'h81);
    push(8'h7E);
    wait_idle(4000);
    STOP2 = 1'b0;

    // Fill the FIFO while a frame is on the line; the fifth byte overflows
    push(8'hF0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      load     = 1'b1;
      OUT_PORT = 8'(k * 37 + 1);
    end
    @(negedge clk);
    load = 1'b0;
    chk("full_LEVEL", 32'(LEVEL), 32'd4);
    chk("full_TXRDY", 32'(TXRDY), 32'd0);
    chk("full_OVF",   32'(OVF),   32'd1);
    wait_idle(8000);

    // Reset during data bit 3 with bytes still queued
    push(8'hC5);
    push(8'h11);
    push(8'h22);
    repeat (4 * 108 + 40) @(negedge clk);
    chk("pre_rst_TX", 32'(TX), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_TX",    32'(TX),    32'd1);
    chk("midrst_LEVEL", 32'(LEVEL), 32'd0);
    chk("midrst_OVF",   32'(OVF),   32'd0);
    chk("midrst_BUSY",  32'(BUSY),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (1500) @(negedge clk);

    // Randomized traffic with configuration changing at arbitrary times
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        DBITS = 2'($urandom);
        PEN   = 1'($urandom);
        OHEL  = 1'($urandom);
        STOP2 = 1'($urandom);
        BAUD  = 4'($urandom_range(10, 15));
      end
      OUT_PORT = 8'($urandom);
      load     = ($urandom_range(0, 299) == 0);
      if (burst_left == 0 && $urandom_range(0, 1999) == 0) burst_left = 6;
      if (burst_left > 0) begin
        load = 1'b1;
        burst_left--;
      end
    end
    @(negedge clk);
    load = 1'b0;
    wait_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz used to derive bit-time divisors.
REQ-002 Parameter DEPTH, default 4, transmit FIFO depth in bytes; power of two, 2..64.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-005 Port load  input  1  write strobe; pushes OUT_PORT into FIFO when TXRDY=1.
REQ-006 Port OUT_PORT  input  8  byte to transmit.
REQ-007 Port DBITS  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-008 Port PEN  input  1  parity enable.
REQ-009 Port OHEL  input  1  parity sense: 1=odd, 0=even.
REQ-010 Port STOP2  input  1  1=two stop bits, 0=one.
REQ-011 Port BAUD  input  4  rate select, table in REQ-016.
REQ-012 Port TXRDY  output  1  FIFO not full.
REQ-013 Port TX  output  1  serial line, registered, idle high.
REQ-014 Port BUSY  output  1  frame in progress or FIFO non-empty.
REQ-015 Port LEVEL  output  clog2(DEPTH)+1  FIFO occupancy. Port OVF  output  1  sticky overflow flag.

Function
REQ-016 Bit time = CLK_HZ/rate clocks, integer-truncated; BAUD 0..11 = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; 12..15 = 921600.
REQ-017 Push accepted only when load=1 and TXRDY=1 at the same edge; LEVEL increments that edge.
REQ-018 load=1 with TXRDY=0: byte dropped, FIFO unchanged, OVF set to 1 and held until reset.
REQ-019 FIFO pointers wrap modulo DEPTH; push and pop on same edge leave LEVEL unchanged; TXRDY=0 exactly when LEVEL=DEPTH.
REQ-020 FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE with LEVEL>0: pop, latch byte, DBITS, PEN, OHEL, STOP2, BAUD; go START; TX=0 from that edge.
REQ-022 Push into empty FIFO while IDLE: TX falls on the edge after the push edge (latency 1 clock).
REQ-023 Bit counter reloads each bit; BTU pulse when count = divisor-1; each state advances only on BTU.
REQ-024 START lasts one bit time, then DATA.
REQ-025 DATA sends DBITS+5 bits LSB first; bits above selected length never sent.
REQ-026 PARITY entered only if latched PEN=1; bit = XOR of sent data bits, inverted when OHEL=1.
REQ-027 STOP drives 1 for one or two bit times per latched STOP2.
REQ-028 End of STOP with LEVEL>0: pop and enter START directly, no idle gap; else IDLE, TX=1.
REQ-029 Config/BAUD changes mid-frame take effect only at next frame start.
REQ-030 BUSY=0 only when state=IDLE and LEVEL=0.

Reset
REQ-031 rst=0 immediately: TX=1, TXRDY=1, BUSY=0, LEVEL=0, OVF=0, state IDLE, counters 0, FIFO emptied.
REQ-032 Reset asserted mid-frame aborts the frame and discards queued bytes; no partial frame resumes after release.
REQ-033 First push accepted on the first rising edge with rst=1.

Verification
REQ-034 CLK_HZ default, BAUD=1011, DBITS=11, PEN=0, STOP2=0, push 0x55 -> TX 0,1,0,1,0,1,0,1,0,1, each bit 108 clocks, then idle 1.
REQ-035 DBITS=10, PEN=1, OHEL=1, push 0x55 -> 7 data bits 1010101, parity 1 (four ones, odd), one stop.
REQ-036 DEPTH=4, BAUD=1011, push five bytes back-to-back -> TXRDY=0 after fourth accepted, fifth dropped, OVF=1, LEVEL=4.
REQ-037 Two bytes queued, STOP2=1 -> second start bit follows 216 stop clocks with no idle gap; BUSY low only after second frame's stop.
REQ-038 Change BAUD 1011->1000 mid-frame -> current frame stays 108 clocks/bit; next frame 868 clocks/bit.
REQ-039 rst=0 during DATA bit 3 -> TX=1 same cycle, LEVEL=0, OVF=0; after release line stays idle high.
